// File: rtl/trigger_capture.sv
// Trigger and capture controller: level/slope trigger with hysteresis, pre-trigger
// history in a circular buffer, frame held with frame_ready until acknowledged.
module trigger_capture #(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int PRETRIG      = 256,
  parameter int HYST         = 4,
  parameter int AUTO_SAMPLES = 2048
) (
  input  logic          osc_clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [7:0]    sample_data,
  input  logic [7:0]    trig_level,
  input  logic          trig_slope,
  input  logic          trig_auto,
  input  logic          arm,
  input  logic          disarm,
  input  logic          frame_ack,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_data,
  output logic [AW-1:0] start_addr,
  output logic [AW-1:0] trig_addr,
  output logic          trig_forced,
  output logic          frame_ready,
  output logic          busy
);

  localparam int POST_LEN = DEPTH - PRETRIG - 1;
  localparam int ACW      = $clog2(AUTO_SAMPLES + 1);

  localparam logic [AW-1:0]  ONE       = AW'(1);
  localparam logic [AW-1:0]  PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0]  PRE_OFS   = AW'(PRETRIG);
  localparam logic [AW-1:0]  POST_LAST = AW'((POST_LEN > 0) ? (POST_LEN - 1) : 0);
  localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_SAMPLES - 1);
  localparam logic [ACW-1:0] AUTO_SAT  = ACW'(AUTO_SAMPLES);
  localparam logic [ACW-1:0] AUTO_ONE  = ACW'(1);
  localparam logic [8:0]     HYST9     = 9'(HYST);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READY     = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]  post_cnt_q, post_cnt_d;
  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
  logic           hyst_q, hyst_d;
  logic           buf_we_q, buf_we_d;
  logic [AW-1:0]  buf_addr_q, buf_addr_d;
  logic [7:0]     buf_data_q, buf_data_d;
  logic [AW-1:0]  start_addr_q, start_addr_d;
  logic [AW-1:0]  trig_addr_q, trig_addr_d;
  logic           trig_forced_q, trig_forced_d;
  logic           frame_ready_q, frame_ready_d;
  logic           busy_q, busy_d;

  logic [8:0] level9_s;
  logic [8:0] sample9_s;
  logic [8:0] lo_thr_s;
  logic [8:0] hi_sum_s;
  logic [8:0] hi_thr_s;
  logic       flag_set_s;
  logic       level_hit_s;
  logic       real_fire_s;
  logic       auto_fire_s;

  // Trigger thresholds (saturating) and per-sample trigger decisions.
  always_comb begin
    level9_s  = {1'b0, trig_level};
    sample9_s = {1'b0, sample_data};
    if (level9_s >= HYST9) begin
      lo_thr_s = level9_s - HYST9;
    end else begin
      lo_thr_s = 9'd0;
    end
    hi_sum_s = level9_s + HYST9;
    if (hi_sum_s > 9'd255) begin
      hi_thr_s = 9'd255;
    end else begin
      hi_thr_s = hi_sum_s;
    end
    if (trig_slope) begin
      flag_set_s  = (sample9_s < lo_thr_s);
      level_hit_s = (sample_data >= trig_level);
    end else begin
      flag_set_s  = (sample9_s > hi_thr_s);
      level_hit_s = (sample_data <= trig_level);
    end
    // Fire uses the flag as it stood before this sample, so a setting sample never fires.
    real_fire_s = hyst_q & level_hit_s;
    if (trig_auto && (auto_cnt_q == AUTO_LAST)) begin
      auto_fire_s = 1'b1;
    end else begin
      auto_fire_s = 1'b0;
    end
  end

  // Next-state, buffer write and frame descriptor logic.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    auto_cnt_d    = auto_cnt_q;
    hyst_d        = hyst_q;
    buf_we_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    start_addr_d  = start_addr_q;
    trig_addr_d   = trig_addr_q;
    trig_forced_d = trig_forced_q;
    frame_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_PREFILL;
          wptr_d     = '0;
          pre_cnt_d  = '0;
          auto_cnt_d = '0;
          hyst_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREFILL: begin
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (sample_valid) begin
          buf_we_d   = 1'b1;
          buf_addr_d = wptr_q;
          buf_data_d = sample_data;
          wptr_d     = wptr_q + ONE;
          pre_cnt_d  = pre_cnt_q + ONE;
          if (pre_cnt_q == PRE_LAST) begin
            state_d = ST_WAIT_TRIG;
          end else begin
            state_d = ST_PREFILL;
          end
        end else begin
          state_d = ST_PREFILL;
        end
      end

      ST_WAIT_TRIG: begin
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (sample_valid) begin
          buf_we_d   = 1'b1;
          buf_addr_d = wptr_q;
          buf_data_d = sample_data;
          wptr_d     = wptr_q + ONE;
          // Saturate so only the exact AUTO_SAMPLES-th sample can force a trigger.
          if (auto_cnt_q != AUTO_SAT) begin
            auto_cnt_d = auto_cnt_q + AUTO_ONE;
          end else begin
            auto_cnt_d = auto_cnt_q;
          end
          if (real_fire_s || auto_fire_s) begin
            trig_addr_d   = wptr_q;
            start_addr_d  = wptr_q - PRE_OFS;
            trig_forced_d = ~real_fire_s;
            post_cnt_d    = '0;
            if (POST_LEN > 0) begin
              state_d = ST_POST;
            end else begin
              state_d = ST_READY;
            end
          end else if (flag_set_s) begin
            hyst_d = 1'b1;
          end else begin
            hyst_d = hyst_q;
          end
        end else begin
          state_d = ST_WAIT_TRIG;
        end
      end

      ST_POST: begin
        if (sample_valid) begin
          buf_we_d   = 1'b1;
          buf_addr_d = wptr_q;
          buf_data_d = sample_data;
          wptr_d     = wptr_q + ONE;
          post_cnt_d = post_cnt_q + ONE;
          if (post_cnt_q == POST_LAST) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_POST;
        end
      end

      ST_READY: begin
        if (frame_ack) begin
          state_d       = ST_IDLE;
          frame_ready_d = 1'b0;
        end else begin
          state_d       = ST_READY;
          frame_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PREFILL) || (state_d == ST_WAIT_TRIG) || (state_d == ST_POST);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      auto_cnt_q    <= '0;
      hyst_q        <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= 8'd0;
      start_addr_q  <= '0;
      trig_addr_q   <= '0;
      trig_forced_q <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      auto_cnt_q    <= auto_cnt_d;
      hyst_q        <= hyst_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      start_addr_q  <= start_addr_d;
      trig_addr_q   <= trig_addr_d;
      trig_forced_q <= trig_forced_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_data    = buf_data_q;
  assign start_addr  = start_addr_q;
  assign trig_addr   = trig_addr_q;
  assign trig_forced = trig_forced_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture with a 16-deep buffer, PRETRIG=4, AUTO_SAMPLES=32.
module tb_trigger_capture;

  logic       osc_clk;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic       trig_auto;
  logic       arm;
  logic       disarm;
  logic       frame_ack;
  logic       buf_we;
  logic [3:0] buf_addr;
  logic [7:0] buf_data;
  logic [3:0] start_addr;
  logic [3:0] trig_addr;
  logic       trig_forced;
  logic       frame_ready;
  logic       busy;

  logic [23:0] all_outs;
  logic [7:0]  mem [0:15];
  int          wr_total;
  int          n_tests;
  int          n_fail;

  trigger_capture #(
    .DEPTH(16), .AW(4), .PRETRIG(4), .HYST(4), .AUTO_SAMPLES(32)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_level(trig_level), .trig_slope(trig_slope),
    .trig_auto(trig_auto), .arm(arm), .disarm(disarm), .frame_ack(frame_ack),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .start_addr(start_addr), .trig_addr(trig_addr), .trig_forced(trig_forced),
    .frame_ready(frame_ready), .busy(busy)
  );

  assign all_outs = {buf_we, buf_addr, buf_data, start_addr, trig_addr,
                     trig_forced, frame_ready, busy};

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  initial wr_total = 0;

  // Buffer model: capture every write seen on the bus.
  always @(negedge osc_clk) begin
    if (buf_we === 1'b1) begin
      mem[buf_addr] <= buf_data;
      wr_total      <= wr_total + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    sample_valid = v;
    sample_data  = d;
    @(negedge osc_clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge osc_clk);
    arm = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge osc_clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    int w0;
    reset = 1'b1;
    repeat (2) @(negedge osc_clk);
    n_tests++;
    if (all_outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want %h", all_outs, 24'd0);
    end
    reset = 1'b0;
    @(negedge osc_clk);
    trig_slope = 1'b1; trig_level = 8'd128; trig_auto = 1'b0;
    do_arm();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_busy: got %b want 1", busy);
    end
    repeat (24) cyc(1'b1, 8'd200);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (all_outs !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset_outs: got %h want %h", all_outs, 24'd0);
    end
    @(negedge osc_clk);
    reset = 1'b0;
    w0 = wr_total;
    repeat (10) cyc(1'b1, 8'd33);
    cyc(1'b0, 8'd0);
    n_tests++;
    if ((wr_total - w0) !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL postreset_idle: got writes %0d busy %b want 0 0", wr_total - w0, busy);
    end
  endtask

  task automatic test_rising_wrap();
    int w0;
    logic [7:0] v;
    logic [7:0] exp;
    trig_slope = 1'b1; trig_level = 8'd128; trig_auto = 1'b0;
    do_arm();
    w0 = wr_total;
    for (int k = 0; k < 28; k++) begin
      v = 8'(8 * k);
      cyc(1'b1, v);
    end
    n_tests++;
    if (buf_we !== 1'b1 || buf_addr !== 4'd11 || frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_lastwr: got we %b addr %0d rdy %b want 1 11 0", buf_we, buf_addr, frame_ready);
    end
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || busy !== 1'b0 || trig_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_ready: got rdy %b busy %b forced %b want 1 0 0", frame_ready, busy, trig_forced);
    end
    n_tests++;
    if (trig_addr !== 4'd0 || start_addr !== 4'd12) begin
      n_fail++;
      $display("FAIL wrap_addrs: got trig %0d start %0d want 0 12", trig_addr, start_addr);
    end
    n_tests++;
    if ((wr_total - w0) !== 28) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 28", wr_total - w0);
    end
    for (int a = 0; a < 16; a++) begin
      exp = (a >= 12) ? 8'(8 * a) : 8'(8 * (a + 16));
      n_tests++;
      if (mem[a] !== exp) begin
        n_fail++;
        $display("FAIL wrap_mem[%0d]: got %0d want %0d", a, mem[a], exp);
      end
    end
    do_ack();
    n_tests++;
    if (frame_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_ack: got rdy %b busy %b want 0 0", frame_ready, busy);
    end
  endtask

  task automatic test_hysteresis();
    trig_slope = 1'b1; trig_level = 8'd128; trig_auto = 1'b0;
    do_arm();
    repeat (4) cyc(1'b1, 8'd200);
    cyc(1'b1, 8'd130);
    cyc(1'b1, 8'd126);
    cyc(1'b1, 8'd130);
    cyc(1'b1, 8'd120);
    cyc(1'b1, 8'd128);
    repeat (11) cyc(1'b1, 8'd60);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || trig_addr !== 4'd8 || start_addr !== 4'd4 || trig_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL hyst_trig: got rdy %b trig %0d start %0d forced %b want 1 8 4 0",
               frame_ready, trig_addr, start_addr, trig_forced);
    end
    do_ack();
  endtask

  task automatic test_falling();
    trig_slope = 1'b0; trig_level = 8'd100; trig_auto = 1'b0;
    do_arm();
    repeat (4) cyc(1'b1, 8'd50);
    cyc(1'b1, 8'd90);
    cyc(1'b1, 8'd110);
    cyc(1'b1, 8'd100);
    repeat (11) cyc(1'b1, 8'd30);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || trig_addr !== 4'd6 || start_addr !== 4'd2 || trig_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_trig: got rdy %b trig %0d start %0d forced %b want 1 6 2 0",
               frame_ready, trig_addr, start_addr, trig_forced);
    end
    do_ack();
  endtask

  task automatic test_auto();
    trig_slope = 1'b1; trig_level = 8'd128; trig_auto = 1'b1;
    do_arm();
    repeat (4) cyc(1'b1, 8'd50);
    repeat (32) cyc(1'b1, 8'd50);
    repeat (11) cyc(1'b1, 8'd50);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || trig_addr !== 4'd3 || start_addr !== 4'd15 || trig_forced !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_trig: got rdy %b trig %0d start %0d forced %b want 1 3 15 1",
               frame_ready, trig_addr, start_addr, trig_forced);
    end
    do_ack();
    // Real trigger landing on the 32nd sample wins over the forced one.
    do_arm();
    repeat (4) cyc(1'b1, 8'd200);
    repeat (31) cyc(1'b1, 8'd100);
    cyc(1'b1, 8'd200);
    repeat (11) cyc(1'b1, 8'd50);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || trig_addr !== 4'd3 || trig_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_prio: got rdy %b trig %0d forced %b want 1 3 0", frame_ready, trig_addr, trig_forced);
    end
    do_ack();
    trig_auto = 1'b0;
    do_arm();
    repeat (4) cyc(1'b1, 8'd50);
    repeat (100) cyc(1'b1, 8'd50);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (busy !== 1'b1 || frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL noauto_wait: got busy %b rdy %b want 1 0", busy, frame_ready);
    end
    disarm = 1'b1;
    cyc(1'b1, 8'd50);
    disarm = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || buf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL disarm_wait: got busy %b we %b want 0 0", busy, buf_we);
    end
  endtask

  task automatic test_handshake();
    int w0;
    trig_slope = 1'b1; trig_level = 8'd128; trig_auto = 1'b0;
    do_arm();
    repeat (4) cyc(1'b1, 8'd200);
    repeat (8) cyc(1'b1, 8'd10);
    cyc(1'b1, 8'd130);
    repeat (11) cyc(1'b1, 8'd70);
    cyc(1'b0, 8'd0);
    n_tests++;
    if (frame_ready !== 1'b1 || trig_addr !== 4'd12 || start_addr !== 4'd8) begin
      n_fail++;
      $display("FAIL hs_frame: got rdy %b trig %0d start %0d want 1 12 8", frame_ready, trig_addr, start_addr);
    end
    w0 = wr_total;
    repeat (5) cyc(1'b1, 8'd99);
    cyc(1'b0, 8'd0);
    n_tests++;
    if ((wr_total - w0) !== 0 || frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_ready_drop: got writes %0d rdy %b want 0 1", wr_total - w0, frame_ready);
    end
    frame_ack = 1'b1;
    arm       = 1'b1;
    @(negedge osc_clk);
    frame_ack = 1'b0;
    arm       = 1'b0;
    n_tests++;
    if (frame_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ack: got rdy %b busy %b want 0 0", frame_ready, busy);
    end
    cyc(1'b0, 8'd0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_arm_ignored: got busy %b want 0", busy);
    end
    do_arm();
    cyc(1'b1, 8'd77);
    n_tests++;
    if (buf_we !== 1'b1 || buf_addr !== 4'd0 || buf_data !== 8'd77 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_rearm: got we %b addr %0d data %0d busy %b want 1 0 77 1",
               buf_we, buf_addr, buf_data, busy);
    end
    disarm = 1'b1;
    cyc(1'b1, 8'd5);
    disarm = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || buf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL disarm_prefill: got busy %b we %b want 0 0", busy, buf_we);
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    trig_level   = 8'd0;
    trig_slope   = 1'b1;
    trig_auto    = 1'b0;
    arm          = 1'b0;
    disarm       = 1'b0;
    frame_ack    = 1'b0;
    test_reset();
    test_rising_wrap();
    test_hysteresis();
    test_falling();
    test_auto();
    test_handshake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Trigger and capture controller between the ADC serial front end and the sample frame buffer. It takes 8-bit samples from the ADC interface and detects a level/slope trigger with hysteresis. It writes one frame of DEPTH samples, with PRETRIG of them before the trigger, into a circular buffer. It then holds the frame and raises `frame_ready` until the Pi-side reader acknowledges it.

## Interface
- `DEPTH`, 1024: frame length in samples; power of two.
- `AW`, 10: buffer address width; DEPTH = 2^AW.
- `PRETRIG`, 256: samples kept before the trigger sample; legal range 1..DEPTH-1.
- `HYST`, 4: hysteresis distance in LSBs.
- `AUTO_SAMPLES`, 2048: number of WAIT_TRIG samples before a forced trigger when `trig_auto`=1.
- `osc_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: one-cycle strobe per new sample. Back-to-back strobes are legal.
- `sample_data` in 8: sample value, unsigned.
- `trig_level` in 8: trigger threshold. Held static while armed.
- `trig_slope` in 1: 1 selects rising edge, 0 selects falling edge. Held static while armed.
- `trig_auto` in 1: enables the forced trigger after AUTO_SAMPLES samples.
- `arm` in 1: starts a capture. Sampled only in IDLE.
- `disarm` in 1: aborts a capture. Sampled in PREFILL and WAIT_TRIG.
- `frame_ack` in 1: reader has consumed the frame. Sampled only in READY.
- `buf_we` out 1: buffer write strobe, one cycle per sample written.
- `buf_addr` out AW: buffer write address.
- `buf_data` out 8: buffer write data.
- `start_addr` out AW: address of the oldest sample of the frame. Valid while `frame_ready`=1.
- `trig_addr` out AW: address of the trigger sample. Valid while `frame_ready`=1.
- `trig_forced` out 1: 1 if the frame was triggered by the auto timeout. Valid while `frame_ready`=1.
- `frame_ready` out 1: frame complete and held.
- `busy` out 1: high in PREFILL, WAIT_TRIG and POST.

## Operation
- Reset state: IDLE. All outputs are 0. The write pointer, counters and the hysteresis flag are all 0.
- IDLE: samples are dropped. `arm`=1 moves to PREFILL, clears the write pointer and pre-count, and clears the hysteresis flag.
- PREFILL: every valid sample is written at the write pointer, then the pointer increments modulo DEPTH. The trigger is not evaluated. After the PRETRIG-th write the state moves to WAIT_TRIG.
- WAIT_TRIG: every valid sample is written circularly. The trigger is evaluated on each sample before it is written.
  - Rising edge: the hysteresis flag sets when sample < trig_level-HYST, with the subtraction saturating at 0. The trigger fires when the flag is set and sample >= trig_level.
  - Falling edge: the flag sets when sample > trig_level+HYST, with the addition saturating at 255. The trigger fires when the flag is set and sample <= trig_level.
  - A sample that sets the flag cannot also fire the trigger.
  - Auto trigger: when `trig_auto`=1, the sample that is the AUTO_SAMPLES-th sample in WAIT_TRIG fires the trigger with `trig_forced`=1. A real trigger on that same sample takes priority, so `trig_forced`=0.
  - On the trigger: `trig_addr` = the write address of the trigger sample, `start_addr` = trig_addr - PRETRIG mod DEPTH, post-count is cleared, and the state moves to POST.
- POST: writes a further DEPTH-PRETRIG-1 samples, then moves to READY. The frame is DEPTH contiguous addresses starting at `start_addr`, with wrap-around.
- READY: samples are dropped and nothing is written. `frame_ack`=1 moves to IDLE. `arm` in the same cycle is ignored; a new capture needs `arm` in IDLE.
- `disarm`=1 in PREFILL or WAIT_TRIG moves to IDLE with no write for that cycle's sample. `disarm` is ignored in POST.
- `reset` asserted at any point returns the block to the reset state immediately. A partial frame is discarded.

## Timing
- A sample strobed in cycle N produces `buf_we`=1, `buf_addr` and `buf_data` registered in cycle N+1, for one cycle only.
- A state change caused by a sample in cycle N is visible in cycle N+1.
- `frame_ready` rises in cycle N+2, where N is the strobe cycle of the final sample. This is one cycle after the final `buf_we`. `start_addr`, `trig_addr` and `trig_forced` are stable from that cycle until `frame_ack` is taken.
- `frame_ack` in cycle M gives `frame_ready`=0 in cycle M+1, with the block in IDLE.
- `arm` in cycle M gives `busy`=1 in cycle M+1. A sample strobed in cycle M+1 is the first sample written.
- `busy` is registered and changes together with the state.

## Test plan
- Reset mid-capture, after 20 samples in WAIT_TRIG -> all outputs 0 in the same cycle. After release and with no `arm`, no `buf_we` occurs.
- Rising trigger with wrap. Setup: DEPTH=16, PRETRIG=4, level=128, samples 8k for k=0,1,2,…. Required response:
  - Exactly 28 writes.
  - The trigger is at k=16, so `trig_addr`=0 and `start_addr`=12.
  - Addresses 12..15 hold 96..120. Addresses 0..11 hold 128..216.
  - `frame_ready` is set one cycle after the last write, and `trig_forced`=0.
- Hysteresis, level=128, rising, after prefill. Feeding 130, 126, 130 -> no trigger. Then feeding 120, 128 -> the trigger fires on 128.
- Falling trigger, level=100. Feeding 90, 110, 100 -> no trigger on 90. The flag is set by 110, and the trigger fires on 100.
- Auto trigger, AUTO_SAMPLES=32, `trig_auto`=1, constant input 50 -> the trigger fires on the 32nd WAIT_TRIG sample with `trig_forced`=1. With `trig_auto`=0 and 100 samples -> the block stays in WAIT_TRIG.
- Handshake. `disarm` in WAIT_TRIG -> IDLE next cycle, with no `buf_we` for the same-cycle sample. Samples strobed during READY are not written. `frame_ack` clears `frame_ready` next cycle, and a subsequent `arm` restarts the capture at address 0.
